mem_arbiter: RTL and testbench

Two-port arbiter that shares the core's single unified memory between the instruction-fetch path and the load/store data path. Sits between `core` and `memory` inside `top`. Accepts one request at a time with valid/ready handshakes, drives the memory port, counts out the fixed memory read latency, and returns the response to the winning requester. Round-robin selection ensures neither port starves when both request every cycle.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_port_t  : requester identity (fetch / load-store)
//   LAT_CNT_WIDTH : width of the read-latency down-counter
package pkg_mem_arbiter;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } arb_port_t;

  localparam int unsigned LAT_CNT_WIDTH = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory between instruction fetch
// and load/store. One transaction in flight at a time: accept in IDLE, count
// out MEM_LATENCY in WAIT, hand the read data to the owner in RESP.
// Ports:
//   clk, reset                     clock, async active-high reset
//   fetch_req_valid/addr/ready     fetch request handshake
//   fetch_resp_valid/rdata         fetch response (1-cycle pulse)
//   data_req_valid/we/be/addr/wdata/ready  load/store request handshake
//   data_resp_valid/rdata          load data / store completion (1-cycle pulse)
//   mem_en/we/be/addr/wdata        memory request strobe (accept cycle only)
//   mem_rdata                      memory read data, valid MEM_LATENCY after mem_en
// MEM_LATENCY legal range is 1..15 (fits the 4-bit latency counter).
module mem_arbiter
  import pkg_mem_arbiter::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    fetch_req_valid,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_req_ready,
  output logic                    fetch_resp_valid,
  output logic [DATA_WIDTH-1:0]   fetch_rdata,

  input  logic                    data_req_valid,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_req_ready,
  output logic                    data_resp_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,

  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [LAT_CNT_WIDTH-1:0] LAT_INIT = LAT_CNT_WIDTH'(MEM_LATENCY - 1);
  localparam logic [LAT_CNT_WIDTH-1:0] LAT_ONE  = LAT_CNT_WIDTH'(1);

  arb_state_t               state;
  arb_state_t               state_nxt;
  arb_port_t                owner;
  arb_port_t                last_grant;
  arb_port_t                winner;
  logic [LAT_CNT_WIDTH-1:0] lat_cnt;
  logic                     any_req;
  logic                     accept;

  // Round-robin pick: on a tie the port that did not win last time goes first.
  always_comb begin
    any_req = fetch_req_valid | data_req_valid;
    winner  = PORT_FETCH;
    if (data_req_valid && (!fetch_req_valid || last_grant == PORT_FETCH)) begin
      winner = PORT_DATA;
    end
  end

  // No grant is visible while reset is held, so nothing reaches memory.
  assign accept = (state == ARB_IDLE) && any_req && !reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Transaction bookkeeping: owner, round-robin history, latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= PORT_FETCH;
      last_grant <= PORT_DATA;
      lat_cnt    <= '0;
    end else if (accept) begin
      owner      <= winner;
      last_grant <= winner;
      lat_cnt    <= LAT_INIT;
    end else if (state == ARB_WAIT && lat_cnt != '0) begin
      lat_cnt <= lat_cnt - LAT_ONE;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_req) state_nxt = ARB_WAIT;
      ARB_WAIT: if (lat_cnt == '0) state_nxt = ARB_RESP;
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Output logic: grant and memory strobe in IDLE, response routing in RESP.
  always_comb begin
    fetch_req_ready  = 1'b0;
    fetch_resp_valid = 1'b0;
    fetch_rdata      = '0;
    data_req_ready   = 1'b0;
    data_resp_valid  = 1'b0;
    data_rdata       = '0;
    mem_en           = 1'b0;
    mem_we           = 1'b0;
    mem_be           = '0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state)
      ARB_IDLE: begin
        if (accept) begin
          mem_en = 1'b1;
          if (winner == PORT_FETCH) begin
            fetch_req_ready = 1'b1;
            mem_be          = '1;
            mem_addr        = fetch_addr;
          end else begin
            data_req_ready = 1'b1;
            mem_we         = data_we;
            mem_be         = data_be;
            mem_addr       = data_addr;
            mem_wdata      = data_wdata;
          end
        end
      end
      ARB_RESP: begin
        if (owner == PORT_FETCH) begin
          fetch_resp_valid = 1'b1;
          fetch_rdata      = mem_rdata;
        end else begin
          data_resp_valid = 1'b1;
          data_rdata      = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a MEM_LATENCY=1 instance (a_*)
// and a MEM_LATENCY=3 instance (b_*), each with a small behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- instance A: MEM_LATENCY = 1 ----------------
  logic        a_fv = 0, a_dv = 0, a_we = 0;
  logic [31:0] a_faddr = '0, a_daddr = '0, a_wd = '0;
  logic [3:0]  a_be = '0;
  logic        a_f_ready, a_f_resp, a_d_ready, a_d_resp;
  logic [31:0] a_f_rdata, a_d_rdata;
  logic        a_mem_en, a_mem_we;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [31:0] a_rdata = '0;
  logic [31:0] mem_a [256];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst),
    .fetch_req_valid(a_fv), .fetch_addr(a_faddr), .fetch_req_ready(a_f_ready),
    .fetch_resp_valid(a_f_resp), .fetch_rdata(a_f_rdata),
    .data_req_valid(a_dv), .data_we(a_we), .data_be(a_be), .data_addr(a_daddr),
    .data_wdata(a_wd), .data_req_ready(a_d_ready), .data_resp_valid(a_d_resp),
    .data_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_rdata)
  );

  // Memory A: write on strobe, read data registered one cycle after strobe and held.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (a_mem_be[b]) mem_a[a_mem_addr[9:2]][8*b +: 8] = a_mem_wdata[8*b +: 8];
      end else begin
        a_rdata <= mem_a[a_mem_addr[9:2]];
      end
    end
  end

  // ---------------- instance B: MEM_LATENCY = 3 ----------------
  logic        b_fv = 0;
  logic [31:0] b_faddr = '0;
  logic        b_dv = 0, b_we = 0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_daddr = '0, b_wd = '0;
  logic        b_f_ready, b_f_resp, b_d_ready, b_d_resp;
  logic [31:0] b_f_rdata, b_d_rdata;
  logic        b_mem_en, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [31:0] b_rdata = '0;
  logic [31:0] mem_b [256];
  logic        b_p1_v = 1'b0, b_p2_v = 1'b0;
  logic [7:0]  b_p1_a = '0, b_p2_a = '0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst),
    .fetch_req_valid(b_fv), .fetch_addr(b_faddr), .fetch_req_ready(b_f_ready),
    .fetch_resp_valid(b_f_resp), .fetch_rdata(b_f_rdata),
    .data_req_valid(b_dv), .data_we(b_we), .data_be(b_be), .data_addr(b_daddr),
    .data_wdata(b_wd), .data_req_ready(b_d_ready), .data_resp_valid(b_d_resp),
    .data_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata)
  );

  // Memory B: read data appears three cycles after the strobe and is held.
  always @(posedge clk) begin
    if (b_p2_v) b_rdata <= mem_b[b_p2_a];
    b_p2_v <= b_p1_v;
    b_p2_a <= b_p1_a;
    b_p1_v <= b_mem_en & ~b_mem_we;
    b_p1_a <= b_mem_addr[9:2];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_a();
    a_fv = 0; a_dv = 0; a_we = 0; a_be = '0;
    a_faddr = '0; a_daddr = '0; a_wd = '0;
  endtask

  // One load/store on port A: accept, wait, response.
  task automatic a_data(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp, input string tag);
    cyc();
    a_dv = 1; a_we = we; a_be = be; a_daddr = addr; a_wd = wd;
    smp();
    chk({tag, "_ready"},  32'(a_d_ready), 32'd1);
    chk({tag, "_fready"}, 32'(a_f_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(a_mem_we), 32'(we));
    chk({tag, "_mem_addr"}, a_mem_addr, addr);
    if (we) begin
      chk({tag, "_mem_be"}, 32'(a_mem_be), 32'(be));
      chk({tag, "_mem_wdata"}, a_mem_wdata, wd);
    end
    cyc();
    idle_a();
    smp();
    chk({tag, "_wait_resp"}, 32'(a_d_resp), 32'd0);
    chk({tag, "_wait_en"}, 32'(a_mem_en), 32'd0);
    cyc();
    smp();
    chk({tag, "_resp"}, 32'(a_d_resp), 32'd1);
    chk({tag, "_fresp"}, 32'(a_f_resp), 32'd0);
    if (!we) chk({tag, "_rdata"}, a_d_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0]  = 32'h0000_0013;
    mem_a[20] = 32'h1122_3344;   // byte address 0x50
    mem_b[1]  = 32'hCAFE_F00D;   // byte address 0x04

    // Reset state: request present but nothing granted while reset is high.
    a_fv = 1;
    cyc();
    smp();
    chk("rst_f_ready", 32'(a_f_ready), 32'd0);
    chk("rst_mem_en",  32'(a_mem_en),  32'd0);
    chk("rst_f_resp",  32'(a_f_resp),  32'd0);
    chk("rst_d_resp",  32'(a_d_resp),  32'd0);
    chk("rst_b_mem_en", 32'(b_mem_en), 32'd0);

    // Single fetch of address 0.
    cyc();
    rst = 0; a_fv = 1; a_faddr = 32'h0;
    smp();
    chk("f1_ready",   32'(a_f_ready), 32'd1);
    chk("f1_dready",  32'(a_d_ready), 32'd0);
    chk("f1_mem_en",  32'(a_mem_en),  32'd1);
    chk("f1_mem_we",  32'(a_mem_we),  32'd0);
    chk("f1_mem_be",  32'(a_mem_be),  32'hF);
    chk("f1_mem_addr", a_mem_addr,    32'h0);
    cyc();
    idle_a();
    smp();
    chk("f1_wait_resp", 32'(a_f_resp), 32'd0);
    chk("f1_wait_en",   32'(a_mem_en), 32'd0);
    cyc();
    smp();
    chk("f1_resp",   32'(a_f_resp), 32'd1);
    chk("f1_rdata",  a_f_rdata,     32'h0000_0013);
    chk("f1_dresp",  32'(a_d_resp), 32'd0);
    chk("f1_drdata", a_d_rdata,     32'h0);
    cyc();
    smp();
    chk("f1_after_resp",  32'(a_f_resp), 32'd0);
    chk("f1_after_rdata", a_f_rdata,     32'h0);

    // Store then load, partial store then load.
    a_data(1'b1, 4'b1111, 32'h40, 32'hDEAD_BEEF, 32'h0, "st40");
    a_data(1'b0, 4'b0000, 32'h40, 32'h0,         32'hDEAD_BEEF, "ld40");
    a_data(1'b1, 4'b0010, 32'h50, 32'h0000_AB00, 32'h0, "st50");
    a_data(1'b0, 4'b0000, 32'h50, 32'h0,         32'h1122_AB44, "ld50");

    // Both ports valid from reset release: F, D, F, D.
    cyc();
    rst = 1;
    idle_a();
    cyc();
    rst = 0;
    a_fv = 1; a_faddr = 32'h0;
    a_dv = 1; a_we = 0; a_daddr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("rr%0d_fready", i), 32'(a_f_ready), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_dready", i), 32'(a_d_ready), 32'((i % 2) == 1));
      cyc();
      smp();
      chk($sformatf("rr%0d_wait_rdy", i), 32'(a_f_ready | a_d_ready), 32'd0);
      cyc();
      smp();
      chk($sformatf("rr%0d_resp_rdy", i), 32'(a_f_ready | a_d_ready), 32'd0);
      chk($sformatf("rr%0d_fresp", i), 32'(a_f_resp), 32'((i % 2) == 0));
      chk($sformatf("rr%0d_dresp", i), 32'(a_d_resp), 32'((i % 2) == 1));
      chk($sformatf("rr%0d_frdata", i), a_f_rdata, ((i % 2) == 0) ? 32'h0000_0013 : 32'h0);
      chk($sformatf("rr%0d_drdata", i), a_d_rdata, ((i % 2) == 1) ? 32'hDEAD_BEEF : 32'h0);
      cyc();
    end
    idle_a();

    // Reset during WAIT after a fetch grant: response dropped, tie goes to fetch.
    cyc();
    a_fv = 1; a_faddr = 32'h0;
    smp();
    chk("rw_ready", 32'(a_f_ready), 32'd1);
    cyc();
    idle_a();
    rst = 1;
    smp();
    chk("rw_resp0", 32'(a_f_resp), 32'd0);
    cyc();
    smp();
    chk("rw_resp1", 32'(a_f_resp), 32'd0);
    chk("rw_dresp1", 32'(a_d_resp), 32'd0);
    cyc();
    rst = 0;
    a_fv = 1; a_faddr = 32'h0;
    a_dv = 1; a_we = 0; a_daddr = 32'h40;
    smp();
    chk("rw_tie_fready", 32'(a_f_ready), 32'd1);
    chk("rw_tie_dready", 32'(a_d_ready), 32'd0);
    cyc();
    idle_a();
    cyc();
    smp();
    chk("rw_post_resp",  32'(a_f_resp), 32'd1);
    chk("rw_post_rdata", a_f_rdata,     32'h0000_0013);

    // MEM_LATENCY = 3 instance: response 4 cycles after accept, strobe only once.
    cyc();
    b_fv = 1; b_faddr = 32'h4;
    smp();
    chk("l3_ready",  32'(b_f_ready), 32'd1);
    chk("l3_mem_en", 32'(b_mem_en),  32'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      b_fv = 0; b_faddr = 32'h0;
      smp();
      chk($sformatf("l3_t%0d_en", k),   32'(b_mem_en), 32'd0);
      chk($sformatf("l3_t%0d_resp", k), 32'(b_f_resp), 32'd0);
    end
    cyc();
    smp();
    chk("l3_resp",  32'(b_f_resp), 32'd1);
    chk("l3_rdata", b_f_rdata,     32'hCAFE_F00D);
    chk("l3_dresp", 32'(b_d_resp), 32'd0);
    chk("l3_en",    32'(b_mem_en), 32'd0);
    cyc();
    smp();
    chk("l3_after_resp",  32'(b_f_resp), 32'd0);
    chk("l3_after_rdata", b_f_rdata,     32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
